// File: rtl/sa_pkg.sv
// Shared constants and row type for the systolic-array output path.
package sa_pkg;
    localparam int SA_COL   = 3;
    localparam int SA_DW    = 9;
    localparam int SA_SEQ_W = 8;

    // One result row: lane k occupies bits [k*SA_DW +: SA_DW].
    typedef logic [SA_COL-1:0][SA_DW-1:0] row_t;
endpackage

// File: rtl/col_row_packer_row_fifo.sv
// row_fifo: synchronous show-ahead FIFO with a registered head word.
// The caller guarantees i_push only when not full (or full with i_pop) and i_pop only when not empty.
module row_fifo #(
    parameter  int W     = 27,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_rdata;
    logic [AW-1:0] w_rd_next;

    assign w_rd_next = r_rd_ptr + AW'(1);
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_rdata;

    // NOTE: storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= w_rd_next;
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (i_pop && !i_push) r_count <= r_count - CW'(1);
            // Head register tracks whichever entry will be at the front after this edge.
            if (i_push && (o_empty || (i_pop && r_count == CW'(1))))
                r_rdata <= i_wdata;
            else if (i_pop && r_count > CW'(1))
                r_rdata <= r_mem[w_rd_next];
        end
    end
endmodule

// File: rtl/col_row_packer.sv
// col_row_packer: reassembles serialized column words into rows and buffers them in a row FIFO.
// Optional ROW_SEQ_EN adds an 8-bit per-row sequence tag on o_row_seq.
module col_row_packer import sa_pkg::*; #(
    parameter  int COL   = SA_COL,
    parameter  int DW    = SA_DW,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DW-1:0]     i_data,
    input  logic              i_wren,
    input  logic              i_clear,
    input  logic              i_row_ready,
    output logic [COL*DW-1:0] o_row_data,
    output logic              o_row_valid,
    output logic [CW-1:0]     o_row_count,
    output logic              o_overflow,
    output logic              o_busy
`ifdef ROW_SEQ_EN
    ,
    output logic [SA_SEQ_W-1:0] o_row_seq
`endif
);
    localparam int RW = COL * DW;
    localparam int LW = $clog2(COL);
    localparam logic [LW-1:0] LAST = LW'(COL - 1);
`ifdef ROW_SEQ_EN
    localparam int FW = RW + SA_SEQ_W;
`else
    localparam int FW = RW;
`endif

    logic [LW-1:0]          r_lane;
    logic [(COL-1)*DW-1:0]  r_asm;
    logic                   r_overflow;
    logic                   w_pop;
    logic                   w_complete;
    logic                   w_push;
    logic                   w_empty;
    logic                   w_full;
    logic [FW-1:0]          w_wdata;
    logic [FW-1:0]          w_rdata;

    assign w_pop      = !w_empty && i_row_ready && !i_clear;
    assign w_complete = i_wren && !i_clear && (r_lane == LAST);
    // A full FIFO still takes the row when the head leaves on the same edge.
    assign w_push     = w_complete && (!w_full || w_pop);

    assign o_row_valid = !w_empty;
    assign o_row_data  = w_rdata[RW-1:0];
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_lane != '0);

`ifdef ROW_SEQ_EN
    logic [SA_SEQ_W-1:0] r_seq;

    assign w_wdata   = {r_seq, i_data, r_asm};
    assign o_row_seq = w_rdata[FW-1:RW];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_seq <= '0;
        else if (i_clear) r_seq <= '0;
        else if (w_push)  r_seq <= r_seq + 1'b1;
    end
`else
    assign w_wdata = {i_data, r_asm};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane     <= '0;
            r_asm      <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_lane     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_wren) begin
                r_lane <= (r_lane == LAST) ? '0 : r_lane + LW'(1);
                // The last lane goes straight into the FIFO, so only lanes 0..COL-2 are held.
                for (int k = 0; k < COL - 1; k++)
                    if (r_lane == LW'(k)) r_asm[k*DW +: DW] <= i_data;
            end
            if (w_complete && !w_push) r_overflow <= 1'b1;
        end
    end

    row_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (o_row_count)
    );
endmodule

// File: tb/tb_col_row_packer.sv
// Directed self-checking bench for col_row_packer (COL=3, DW=9, DEPTH=4); ROW_SEQ_EN adds tag checks.
module tb_col_row_packer;
    import sa_pkg::*;

    localparam int COL   = 3;
    localparam int DW    = 9;
    localparam int DEPTH = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [DW-1:0]     i_data;
    logic              i_wren;
    logic              i_clear;
    logic              i_row_ready;
    logic [COL*DW-1:0] o_row_data;
    logic              o_row_valid;
    logic [2:0]        o_row_count;
    logic              o_overflow;
    logic              o_busy;
`ifdef ROW_SEQ_EN
    logic [7:0]        o_row_seq;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    col_row_packer #(.COL(COL), .DW(DW), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_wren      (i_wren),
        .i_clear     (i_clear),
        .i_row_ready (i_row_ready),
        .o_row_data  (o_row_data),
        .o_row_valid (o_row_valid),
        .o_row_count (o_row_count),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy)
`ifdef ROW_SEQ_EN
        ,
        .o_row_seq   (o_row_seq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int r, input int k);
        return DW'(9'h100 | ((r * 4 + k) & 8'hff));
    endfunction

    function automatic logic [COL*DW-1:0] row_of(input int r);
        row_t t;
        for (int k = 0; k < COL; k++) t[k] = word_of(r, k);
        return t;
    endfunction

    task automatic write_word(input logic [DW-1:0] d);
        i_data = d;
        i_wren = 1'b1;
        @(posedge i_clk);
        #1;
        i_wren = 1'b0;
    endtask

    task automatic write_row(input int r);
        for (int k = 0; k < COL; k++) write_word(word_of(r, k));
    endtask

    task automatic pop_one();
        i_row_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_row_ready = 1'b0;
    endtask

    task automatic clear_pulse();
        i_clear = 1'b1;
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_data = '0; i_wren = 1'b0; i_clear = 1'b0; i_row_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_valid", o_row_valid, 0);
        check("reset_count", o_row_count, 0);
        check("reset_ovf",   o_overflow,  0);
        check("reset_busy",  o_busy,      0);
        check("reset_data",  o_row_data,  0);
        i_rst_n = 1'b1;

        // First row, hand-computed concatenation.
        write_word(9'h101);
        check("t1_busy_mid",  o_busy,      1);
        check("t1_valid_mid", o_row_valid, 0);
        write_word(9'h0A2);
        write_word(9'h1FF);
        check("t1_valid", o_row_valid, 1);
        check("t1_data",  o_row_data,  {9'h1FF, 9'h0A2, 9'h101});
        check("t1_count", o_row_count, 1);
        check("t1_busy",  o_busy,      0);
        pop_one();
        check("t1_pop_valid", o_row_valid, 0);
        check("t1_pop_count", o_row_count, 0);

        // Five rows into a four-deep FIFO with no reader: row 5 dropped.
        for (int r = 1; r <= 3; r++) write_row(r);
        check("t2_count3", o_row_count, 3);
        write_row(4);
        write_row(5);
        check("t2_count", o_row_count, 4);
        check("t2_ovf",   o_overflow,  1);
        check("t2_head",  o_row_data,  row_of(1));
        for (int r = 1; r <= 4; r++) begin
            check($sformatf("t2_drain_valid%0d", r), o_row_valid, 1);
            check($sformatf("t2_drain_data%0d", r),  o_row_data,  row_of(r));
            pop_one();
        end
        check("t2_empty",      o_row_valid, 0);
        check("t2_ovf_sticky", o_overflow,  1);

        // Clear with rows buffered, a partial row and a pending word/pop.
        write_row(6);
        write_row(7);
        write_word(word_of(8, 0));
        check("t3_busy_pre",  o_busy,      1);
        check("t3_count_pre", o_row_count, 2);
        i_clear = 1'b1; i_wren = 1'b1; i_row_ready = 1'b1; i_data = word_of(8, 1);
        @(posedge i_clk);
        #1;
        i_clear = 1'b0; i_wren = 1'b0; i_row_ready = 1'b0;
        check("t3_valid", o_row_valid, 0);
        check("t3_count", o_row_count, 0);
        check("t3_ovf",   o_overflow,  0);
        check("t3_busy",  o_busy,      0);

        // Full FIFO with a pop on the edge that completes the fifth row.
        for (int r = 10; r <= 13; r++) write_row(r);
        check("t4_full", o_row_count, 4);
        write_word(word_of(14, 0));
        write_word(word_of(14, 1));
        i_row_ready = 1'b1;
        write_word(word_of(14, 2));
        i_row_ready = 1'b0;
        check("t4_count", o_row_count, 4);
        check("t4_ovf",   o_overflow,  0);
        check("t4_head",  o_row_data,  row_of(11));
        for (int r = 11; r <= 14; r++) begin
            check($sformatf("t4_drain%0d", r), o_row_data, row_of(r));
            pop_one();
        end
        check("t4_empty", o_row_valid, 0);

        // Back-to-back rows with the reader always ready.
        i_row_ready = 1'b1;
        for (int r = 20; r <= 25; r++) begin
            write_row(r);
            check($sformatf("t5_valid%0d", r), o_row_valid, 1);
            check($sformatf("t5_data%0d", r),  o_row_data,  row_of(r));
            check($sformatf("t5_count%0d", r), o_row_count, 1);
        end
        @(posedge i_clk);
        #1;
        i_row_ready = 1'b0;
        check("t5_drained", o_row_valid, 0);

        // Reset in the middle of a row.
        write_word(9'h055);
        write_word(9'h066);
        check("t6_busy_pre", o_busy, 1);
        i_rst_n = 1'b0;
        #2;
        check("t6_busy_rst", o_busy,     0);
        check("t6_data_rst", o_row_data, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        write_word(9'h001);
        write_word(9'h002);
        write_word(9'h003);
        check("t6_data",  o_row_data,  {9'h003, 9'h002, 9'h001});
        check("t6_count", o_row_count, 1);
        check("t6_busy",  o_busy,      0);
        pop_one();

`ifdef ROW_SEQ_EN
        // Sequence tags wrap after 256 accepted rows.
        clear_pulse();
        i_row_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            write_row(i);
            check($sformatf("t7_seq%0d", i), o_row_seq, 8'(i));
        end
        @(posedge i_clk);
        #1;
        i_row_ready = 1'b0;
        // A dropped row leaves no gap in numbering.
        clear_pulse();
        for (int r = 30; r <= 34; r++) write_row(r);
        check("t7_ovf", o_overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t7_drop_seq%0d", i), o_row_seq, 8'(i));
            pop_one();
        end
        write_row(35);
        check("t7_after_drop", o_row_seq, 8'd4);
        pop_one();
`else
        clear_pulse();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
